// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the boot-loaded instruction store.
// Holds the default memory depth, the loader state encoding and the
// zero word returned by the fetch port whenever a read is not allowed.
package inst_rom_loader_pkg;

  // Default depth of the instruction store as log2 of 32-bit words (1024 words = 4 KB)
  localparam int INST_MEM_NUM_LOG2 = 10;

  // Value driven onto the fetch port when no instruction is available
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // LOAD: image is streaming in and the CPU is held in reset
  // RUN : image is complete and the CPU fetches from the store
  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_RUN  = 1'b1
  } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_ld_byte_packer.sv
// Packs the big-endian loader byte stream into 32-bit instruction words.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   clear_i       synchronous restart of the packer (start of a reload)
//   take_i        a byte transfer happens this cycle
//   byte_i        byte being transferred
//   last_i        this byte is the final byte of the image
//   wordValid_o   a word is complete this cycle (full word or padded final word)
//   word_o        the completed word, valid while wordValid_o is high
//   partial_o     the completed word is a zero-padded partial final word
module ld_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic        wordValid_o,
  output logic [31:0] word_o,
  output logic        partial_o
);

  logic [1:0]  phase_q, phase_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] merged;

  // The word register is cleared after every emitted word, so any byte lane
  // not yet filled is already zero. That gives zero-padding of a partial
  // final word for free. The completed word is presented combinationally so
  // the 4th byte lands in memory on the same edge it is accepted.
  always_comb begin
    merged      = shift_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    wordValid_o = 1'b0;
    partial_o   = 1'b0;

    case (phase_q)
      2'd0:    merged[31:24] = byte_i;
      2'd1:    merged[23:16] = byte_i;
      2'd2:    merged[15:8]  = byte_i;
      default: merged[7:0]   = byte_i;
    endcase

    if (take_i) begin
      wordValid_o = (phase_q == 2'd3) || last_i;
      partial_o   = last_i && (phase_q != 2'd3);
    end

    if (clear_i) begin
      shift_d = ZERO_WORD;
      phase_d = 2'd0;
    end else if (take_i) begin
      if (wordValid_o) begin
        shift_d = ZERO_WORD;
        phase_d = 2'd0;
      end else begin
        shift_d = merged;
        phase_d = phase_q + 2'd1;
      end
    end

    word_o = merged;
  end

  // Byte phase and partially assembled word; reset discards any partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 2'd0;
      shift_q <= ZERO_WORD;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction store for the CPU fetch port, filled at boot from a byte stream.
// The CPU is held in reset until the image has been loaded.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   rom_ce_i      fetch enable from the CPU
//   rom_addr_i    byte address from the CPU pc (low two bits ignored)
//   rom_data_o    instruction word, combinational from the store
//   ld_valid_i    loader byte valid
//   ld_byte_i     loader byte, big-endian within a word
//   ld_last_i     marks the final byte of the image
//   ld_ready_o    a byte is accepted when ld_valid_i and ld_ready_o are both high
//   ld_start_i    one-cycle pulse requesting a reload while running
//   cpu_rst_o     holds the CPU in reset
//   load_done_o   image loaded, CPU released
//   load_err_o    sticky: store overflow or partial final word
//   word_cnt_o    number of words written in the current load
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int INST_MEM_LOG2 = INST_MEM_NUM_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rom_ce_i,
  input  logic [31:0]              rom_addr_i,
  output logic [31:0]              rom_data_o,
  input  logic                     ld_valid_i,
  input  logic [7:0]               ld_byte_i,
  input  logic                     ld_last_i,
  output logic                     ld_ready_o,
  input  logic                     ld_start_i,
  output logic                     cpu_rst_o,
  output logic                     load_done_o,
  output logic                     load_err_o,
  output logic [INST_MEM_LOG2:0]   word_cnt_o
);

  localparam int DEPTH = 1 << INST_MEM_LOG2;

  ld_state_e              state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   cpuRst_q, cpuRst_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [INST_MEM_LOG2:0] wordCnt_q, wordCnt_d;

  logic [31:0] mem_q [DEPTH];

  logic        transfer;
  logic        reloadReq;
  logic        storeFull;
  logic        memWe;
  logic        pkWordValid;
  logic [31:0] pkWord;
  logic        pkPartial;
  logic        unusedAddrBits;

  // Fetches are always word-aligned, so the byte offset is dropped
  assign unusedAddrBits = ^rom_addr_i[1:0];

  assign transfer  = ld_valid_i && ready_q;
  assign reloadReq = (state_q == LD_RUN) && ld_start_i;
  // The count saturates at exactly DEPTH, so its top bit alone means "full"
  assign storeFull = wordCnt_q[INST_MEM_LOG2];
  assign memWe     = transfer && pkWordValid && !storeFull;

  ld_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (reloadReq),
    .take_i      (transfer),
    .byte_i      (ld_byte_i),
    .last_i      (ld_last_i),
    .wordValid_o (pkWordValid),
    .word_o      (pkWord),
    .partial_o   (pkPartial)
  );

  // Loader FSM and counters. Every status output is a register so the CPU
  // and loader see clean levels; they all change on the edge after the
  // deciding event (last byte accepted, or reload pulse).
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    cpuRst_d  = cpuRst_q;
    done_d    = done_q;
    err_d     = err_q;
    wordCnt_d = wordCnt_q;

    case (state_q)
      LD_LOAD: begin
        if (transfer) begin
          if (pkWordValid) begin
            if (storeFull) begin
              err_d = 1'b1;
            end else begin
              wordCnt_d = wordCnt_q + 1'b1;
            end
          end
          if (pkPartial) begin
            err_d = 1'b1;
          end
          if (ld_last_i) begin
            state_d  = LD_RUN;
            ready_d  = 1'b0;
            cpuRst_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      LD_RUN: begin
        if (ld_start_i) begin
          state_d   = LD_LOAD;
          ready_d   = 1'b1;
          cpuRst_d  = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          wordCnt_d = '0;
        end
      end
      default: begin
        state_d = LD_LOAD;
      end
    endcase
  end

  // State and status registers; reset restarts the load but keeps memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LD_LOAD;
      ready_q   <= 1'b1;
      cpuRst_q  <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wordCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cpuRst_q  <= cpuRst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wordCnt_q <= wordCnt_d;
    end
  end

  // Instruction store write port; contents survive reset by design
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[wordCnt_q[INST_MEM_LOG2-1:0]] <= pkWord;
    end
  end

  // Zero-latency fetch. Reads are blocked while loading, which also removes
  // any same-cycle read/write collision on one word.
  always_comb begin
    rom_data_o = ZERO_WORD;
    if (rom_ce_i && (state_q == LD_RUN) &&
        (rom_addr_i[31:INST_MEM_LOG2+2] == '0)) begin
      rom_data_o = mem_q[rom_addr_i[INST_MEM_LOG2+1:2]];
    end
  end

  assign ld_ready_o  = ready_q;
  assign cpu_rst_o   = cpuRst_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  assign word_cnt_o  = wordCnt_q;

endmodule
